// File: rtl/fifo_uart_tx_if.sv
// CPU-side write port of the buffered UART transmitter: write strobe, data and FIFO status.
interface fifo_uart_tx_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                wr;
    logic [7:0]          tx_data;
    logic                full;
    logic                empty;
    logic                busy;
    logic [DEPTH_LOG2:0] level;

    modport master (output wr, tx_data, input full, empty, busy, level);
    modport slave  (input wr, tx_data, output full, empty, busy, level);
endinterface

// File: rtl/fifo_uart_tx.sv
// Buffered UART transmitter: synchronous FIFO feeding an 8N1 serializer gated by CTS.
// Define FIFO_UART_TX_PARITY_EN to add an even-parity bit (8E1, 11 bit cells per frame).
module fifo_uart_tx #(
    parameter int FREQ_HZ    = 10000000,
    parameter int BAUDS      = 115200,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cts,
    output logic          tx,
    fifo_uart_tx_if.slave bus
);
    localparam int DIV   = FREQ_HZ / BAUDS;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2(DIV);
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic [7:0]          mem [DEPTH];
    logic [DEPTH_LOG2:0] wptr, rptr, wptr_nxt, rptr_nxt;
    logic                full_q, empty_q;
    logic                push, pop;
    logic [7:0]          head;

    logic [1:0]          cts_sync;
    logic                cts_s;

    logic [2:0]          state;
    logic [CW-1:0]       cnt;
    logic [2:0]          bit_idx;
    logic [7:0]          shreg;
    logic                tx_q;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                parity_q;
`endif

    // A write while full is dropped even if a pop frees a slot on the same edge.
    assign push     = bus.wr && !full_q;
    // The serializer only pops at a frame boundary, and only when the peer is ready.
    assign pop      = cts_s && !empty_q &&
                      ((state == S_IDLE) || (state == S_STOP && cnt == '0));
    assign wptr_nxt = push ? wptr + 1'b1 : wptr;
    assign rptr_nxt = pop  ? rptr + 1'b1 : rptr;
    assign head     = mem[rptr[DEPTH_LOG2-1:0]];
    assign cts_s    = cts_sync[1];

    assign bus.full  = full_q;
    assign bus.empty = empty_q;
    assign bus.level = wptr - rptr;
    assign bus.busy  = !empty_q || (state != S_IDLE);
    assign tx        = tx_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            cts_sync <= 2'b00;
        end else begin
            wptr     <= wptr_nxt;
            rptr     <= rptr_nxt;
            empty_q  <= (wptr_nxt == rptr_nxt);
            full_q   <= (wptr_nxt[DEPTH_LOG2] != rptr_nxt[DEPTH_LOG2]) &&
                        (wptr_nxt[DEPTH_LOG2-1:0] == rptr_nxt[DEPTH_LOG2-1:0]);
            cts_sync <= {cts_sync[0], cts};
        end
    end

    // NOTE: storage needs no reset; resetting the pointers already discards its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[DEPTH_LOG2-1:0]] <= bus.tx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state    <= S_START;
                        cnt      <= RELOAD;
                        shreg    <= head;
                        tx_q     <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
                        parity_q <= ^head;
`endif
                    end
                end
                S_START: begin
                    if (cnt == '0) begin
                        state   <= S_DATA;
                        cnt     <= RELOAD;
                        bit_idx <= '0;
                        tx_q    <= shreg[0];
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == '0) begin
                        cnt <= RELOAD;
                        if (bit_idx == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                            state <= S_PARITY;
                            tx_q  <= parity_q;
`else
                            state <= S_STOP;
                            tx_q  <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= shreg >> 1;
                            tx_q    <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (cnt == '0) begin
                        state <= S_STOP;
                        cnt   <= RELOAD;
                        tx_q  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt == '0) begin
                        // Chain straight into the next start bit so queued bytes leave with no gap.
                        if (pop) begin
                            state    <= S_START;
                            cnt      <= RELOAD;
                            shreg    <= head;
                            tx_q     <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
                            parity_q <= ^head;
`endif
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end
endmodule
